// File: rtl/uart_tx_serializer_if.sv
// Purpose: byte handshake and frame-format bundle between a byte source and the UART serializer.
// Latency: none, wires only.
// Backpressure: tx_ready (slave -> master) gates every byte; config is sampled with the byte.
// Ports (per modport):
//   master: drives tx_data, tx_valid, data_bit_num, stop_bit_num, parity_en, parity_type; reads tx_ready
//   slave : reads the above; drives tx_ready
interface uart_tx_serializer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] data_bit_num;  // 00=5 .. 11=8 data bits
  logic       stop_bit_num;  // 0=1 stop bit, 1=2 stop bits
  logic       parity_en;
  logic       parity_type;   // 0=even, 1=odd

  modport master (
    output tx_data, tx_valid, data_bit_num, stop_bit_num, parity_en, parity_type,
    input  tx_ready
  );

  modport slave (
    input  tx_data, tx_valid, data_bit_num, stop_bit_num, parity_en, parity_type,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// Purpose: UART transmit framer: start, 5-8 data bits LSB first, optional parity, 1-2 stop bits.
// Latency: start bit appears on tx the edge a byte is accepted; frame = (1+N+P+S)*CLKS_PER_BIT cycles.
// Backpressure: tx_ready only when idle and synchronized cts_n is low; a started frame always completes.
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   bus (slave)        : tx_data/tx_valid/tx_ready handshake plus frame format, sampled on accept
//   cts_n              : clear-to-send from the receiver, asynchronous, active-low
//   tx, tx_busy        : serial line (idle high), frame in progress
//   tx_done            : high during the final clock of the last stop bit
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  uart_tx_serializer_if.slave        bus,
  input  logic                       cts_n,
  output logic                       tx,
  output logic                       tx_busy,
  output logic                       tx_done
);

  localparam int               CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       idx_q, idx_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;

  // Frame contents captured at acceptance; inputs are ignored afterwards.
  logic [7:0]       data_q;
  logic [1:0]       nbits_q;
  logic             stop2_q;
  logic             par_en_q;
  logic             par_odd_q;

  logic             cts_meta_q, cts_s_q;
  logic             ready;
  logic             accept;
  logic             load;
  logic             bit_end;
  logic [2:0]       idx_nxt;
  logic [2:0]       data_last;
  logic [2:0]       stop_last;
  logic             par_bit;

  // Two-flop synchronizer, preset high so nothing is accepted until cts_n is seen low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cts_meta_q <= 1'b1;
      cts_s_q    <= 1'b1;
    end else begin
      cts_meta_q <= cts_n;
      cts_s_q    <= cts_meta_q;
    end
  end

  assign ready        = (state_q == S_IDLE) & ~cts_s_q;
  assign bus.tx_ready = ready;
  assign accept       = bus.tx_valid & ready;

  assign bit_end   = (baud_q == CNT_LAST);
  assign idx_nxt   = idx_q + 3'd1;
  // Index of the last data bit: N-1 = 4 + data_bit_num.
  assign data_last = {1'b1, nbits_q};
  assign stop_last = {2'b00, stop2_q};

  // Parity over only the bits actually sent; odd parity inverts the even result.
  always_comb begin
    par_bit = par_odd_q;
    for (int i = 0; i < 8; i++) begin
      if (3'(i) <= data_last) begin
        par_bit = par_bit ^ data_q[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    load    = 1'b0;

    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + CNT_W'(1);
    end

    // tx_d is the value for the next bit period, so tx is a clean register output.
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          baud_d  = '0;
          idx_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          load    = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
          tx_d    = data_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          idx_d = '0;
          if (idx_q != data_last) begin
            idx_d = idx_nxt;
            tx_d  = data_q[idx_nxt];
          end else if (par_en_q) begin
            state_d = S_PARITY;
            tx_d    = par_bit;
          end else begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          idx_d   = '0;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (idx_q == stop_last) begin
            state_d = S_IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_nxt;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        idx_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q    <= '0;
      nbits_q   <= '0;
      stop2_q   <= 1'b0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
    end else if (load) begin
      data_q    <= bus.tx_data;
      nbits_q   <= bus.data_bit_num;
      stop2_q   <= bus.stop_bit_num;
      par_en_q  <= bus.parity_en;
      par_odd_q <= bus.parity_type;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  // Combinational from registers so it is exactly the last cycle of the last stop bit.
  assign tx_done = (state_q == S_STOP) & bit_end & (idx_q == stop_last);

endmodule
